fpu_fp32_div: RTL and testbench

Iterative single-precision divider, the inverse operation of the FPU's combinational FP32 multiplier. It computes dst = srca / srcb with a restoring shift-subtract divider, one quotient bit per clock. It sits beside the multiplier in the FPU execute path and uses a start/done handshake so the pipeline can stall on it. Number-format rules match the multiplier: denormals flush to zero, results truncate, no rounding, and exponent 255 gets no special decode.

---
 rtl/fpu_fp32_div.sv | 161 ++++++++++++++++
 tb/tb_fpu_fp32_div.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_fp32_div.sv
// FP32 iterative divider: restoring shift-subtract, one quotient bit per clock.
// Denormals flush to zero, truncating, start/done handshake toward the pipeline.
module fpu_fp32_div #(
  parameter bit SPECIAL_FAST = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] srca,
  input  logic [31:0] srcb,
  output logic        busy,
  output logic        done,
  output logic [31:0] dst
);

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    PACK,
    DONE
  } state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic        sgnc;
  logic [7:0]  ea;
  logic [7:0]  eb;
  logic [24:0] rem;
  logic [23:0] mb;
  logic [24:0] q;
  logic        spec;
  logic [31:0] specv;

  logic [7:0]  ea_in;
  logic [7:0]  eb_in;
  logic        sgn_in;
  logic        za;
  logic        zb;
  logic        spec_in;
  logic [31:0] specv_in;

  logic        rem_ge;
  logic [24:0] rem_sub;
  logic [24:0] rem_nxt;

  logic [9:0]  exc;
  logic [22:0] frac;
  logic        uf;
  logic        ov;
  logic [31:0] res;

  assign ea_in   = srca[30:23];
  assign eb_in   = srcb[30:23];
  assign sgn_in  = srca[31] ^ srcb[31];
  assign za      = (ea_in == 8'd0);
  assign zb      = (eb_in == 8'd0);
  assign spec_in = za | zb;

  // special-operand result, chosen when the request is accepted
  always_comb begin
    specv_in = 32'h0;
    unique case (1'b1)
      za && zb:  specv_in = 32'h7FC0_0000;
      za && !zb: specv_in = {sgn_in, 31'h0};
      !za && zb: specv_in = {sgn_in, 8'hFF, 23'h0};
      default:   specv_in = 32'h0;
    endcase
  end

  // one restoring step: subtract when the divisor fits, then shift
  always_comb begin
    rem_ge  = (rem >= {1'b0, mb});
    rem_sub = rem - {1'b0, mb};
    rem_nxt = {rem[23:0], 1'b0};
    if (rem_ge) begin
      rem_nxt = {rem_sub[23:0], 1'b0};
    end
  end

  // normalise the quotient and build the packed result
  always_comb begin
    exc  = {2'b00, ea} - {2'b00, eb}
         + (q[24] ? 10'd127 : 10'd126);
    frac = q[24] ? q[23:1] : q[22:0];
    uf   = exc[9] | (exc == 10'd0);
    ov   = !uf && exc[8];
    res  = {sgnc, exc[7:0], frac};
    unique case (1'b1)
      spec:        res = specv;
      !spec && uf: res = 32'h0;
      !spec && ov: res = {sgnc, 8'hFF, 23'h0};
      default:     ;
    endcase
  end

  // control FSM with registered handshake and result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      dst   <= 32'h0;
      cnt   <= 5'd0;
      sgnc  <= 1'b0;
      ea    <= 8'd0;
      eb    <= 8'd0;
      rem   <= 25'd0;
      mb    <= 24'd0;
      q     <= 25'd0;
      spec  <= 1'b0;
      specv <= 32'h0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy  <= 1'b1;
            sgnc  <= sgn_in;
            ea    <= ea_in;
            eb    <= eb_in;
            rem   <= {2'b01, srca[22:0]};
            mb    <= {1'b1, srcb[22:0]};
            q     <= 25'd0;
            cnt   <= 5'd24;
            spec  <= spec_in;
            specv <= specv_in;
            if (SPECIAL_FAST && spec_in) begin
              state <= PACK;
            end else begin
              state <= DIV;
            end
          end
        end
        DIV: begin
          q   <= {q[23:0], rem_ge};
          rem <= rem_nxt;
          cnt <= cnt - 5'd1;
          if (cnt == 5'd0) begin
            state <= PACK;
          end
        end
        PACK: begin
          dst   <= res;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_fp32_div.sv
// Bench for fpu_fp32_div: vector table, random ops against a model,
// and hand sequences for ignored starts, back-to-back and mid-op reset.
module tb_fpu_fp32_div;

  logic        clk;
  logic        rst_n;
  logic        st1;
  logic        st0;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic        busy1;
  logic        done1;
  logic [31:0] dst1;
  logic        busy0;
  logic        done0;
  logic [31:0] dst0;

  int tests;
  int fails;

  fpu_fp32_div #(.SPECIAL_FAST(1'b1)) dut_fast (
    .clk  (clk),
    .rst_n(rst_n),
    .start(st1),
    .srca (srca),
    .srcb (srcb),
    .busy (busy1),
    .done (done1),
    .dst  (dst1)
  );

  fpu_fp32_div #(.SPECIAL_FAST(1'b0)) dut_slow (
    .clk  (clk),
    .rst_n(rst_n),
    .start(st0),
    .srca (srca),
    .srcb (srcb),
    .busy (busy0),
    .done (done0),
    .dst  (dst0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
  } vec_t;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  function automatic bit is_spec(input logic [31:0] a,
                                 input logic [31:0] b);
    return (a[30:23] == 8'd0) || (b[30:23] == 8'd0);
  endfunction

  // quotient of the significands, truncated, then exponent rules
  function automatic logic [31:0] model(input logic [31:0] a,
                                        input logic [31:0] b);
    int     ea, eb, e;
    longint ma, mb, qq;
    logic   s;
    logic [63:0] qb;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (ea == 0 && eb == 0) return 32'h7FC00000;
    if (ea == 0) return {s, 31'h0};
    if (eb == 0) return {s, 8'hFF, 23'h0};
    ma = longint'({1'b1, a[22:0]});
    mb = longint'({1'b1, b[22:0]});
    qq = (ma << 24) / mb;
    if (qq >= (longint'(1) << 24)) begin
      e  = ea - eb + 127;
      qq = qq >> 1;
    end else begin
      e  = ea - eb + 126;
    end
    if (e <= 0) return 32'h0;
    if (e >= 256) return {s, 8'hFF, 23'h0};
    qb = 64'(qq);
    return {s, e[7:0], qb[22:0]};
  endfunction

  task automatic op(input logic [31:0] a,
                    input logic [31:0] b,
                    input bit slow,
                    output logic [31:0] r,
                    output int lat,
                    output int bbad);
    logic d, bz;
    @(negedge clk);
    srca = a;
    srcb = b;
    if (slow) st0 = 1'b1;
    else st1 = 1'b1;
    @(posedge clk);
    #1;
    st0 = 1'b0;
    st1 = 1'b0;
    lat  = 1;
    bbad = 0;
    d  = slow ? done0 : done1;
    bz = slow ? busy0 : busy1;
    while (!d && lat < 40) begin
      if (!bz) bbad++;
      @(posedge clk);
      #1;
      lat++;
      d  = slow ? done0 : done1;
      bz = slow ? busy0 : busy1;
    end
    if (bz) bbad++;
    r = slow ? dst0 : dst1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t        vt[$];
    logic [31:0] r;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    int          bb;
    int          nd;
    int          dc;
    int          dc2;
    logic [31:0] dr;

    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    st1   = 1'b0;
    st0   = 1'b0;
    srca  = 32'h0;
    srcb  = 32'h0;

    vt.push_back('{32'h40C00000, 32'h40000000, 32'h40400000});
    vt.push_back('{32'h3F800000, 32'h40400000, 32'h3EAAAAAA});
    vt.push_back('{32'hBF800000, 32'h3F800000, 32'hBF800000});
    vt.push_back('{32'hBF800000, 32'h00000000, 32'hFF800000});
    vt.push_back('{32'h00000000, 32'h00000000, 32'h7FC00000});
    vt.push_back('{32'h00000000, 32'hC0000000, 32'h80000000});
    vt.push_back('{32'h7F000000, 32'h3E800000, 32'h7F800000});
    vt.push_back('{32'h00800000, 32'h4B000000, 32'h00000000});
    vt.push_back('{32'h80800000, 32'h4B000000, 32'h00000000});
    vt.push_back('{32'h3F800000, 32'h00400000, 32'h7F800000});
    vt.push_back('{32'h7F800000, 32'h40000000, 32'h7F000000});
    vt.push_back('{32'h3F800000, 32'h3F800000, 32'h3F800000});

    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 32'(busy1), 32'h0);
    check("reset done", 32'(done1), 32'h0);
    check("reset dst", dst1, 32'h0);
    check("reset dst slow", dst0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vt[i]) begin
      op(vt[i].a, vt[i].b, 1'b0, r, lat, bb);
      check($sformatf("vec%0d dst", i), r, vt[i].r);
      check($sformatf("vec%0d lat", i), 32'(lat),
            is_spec(vt[i].a, vt[i].b) ? 32'd2 : 32'd27);
      check($sformatf("vec%0d busy", i), 32'(bb), 32'd0);
    end

    foreach (vt[i]) begin
      op(vt[i].a, vt[i].b, 1'b1, r, lat, bb);
      check($sformatf("slow vec%0d dst", i), r, vt[i].r);
      check($sformatf("slow vec%0d lat", i), 32'(lat), 32'd27);
      check($sformatf("slow vec%0d busy", i), 32'(bb), 32'd0);
    end

    for (int k = 0; k < 160; k++) begin
      bit sl;
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 9) == 0) a[30:23] = 8'd0;
      if ($urandom_range(0, 9) == 0) b[30:23] = 8'd0;
      sl = (k % 4) == 3;
      op(a, b, sl, r, lat, bb);
      check($sformatf("rnd%0d %h/%h", k, a, b), r, model(a, b));
      check($sformatf("rnd%0d lat", k), 32'(lat),
            (!sl && is_spec(a, b)) ? 32'd2 : 32'd27);
    end

    // second start during busy with other operands is ignored
    @(negedge clk);
    srca = 32'h40C00000;
    srcb = 32'h40000000;
    st1  = 1'b1;
    @(posedge clk);
    #1;
    st1 = 1'b0;
    nd = 0;
    dc = 0;
    dr = 32'h0;
    for (int c = 1; c < 70; c++) begin
      if (c == 10) begin
        srca = 32'h3F800000;
        srcb = 32'h40400000;
        st1  = 1'b1;
      end
      if (c == 11) st1 = 1'b0;
      if (done1) begin
        nd++;
        dc = c;
        dr = dst1;
      end
      @(posedge clk);
      #1;
    end
    check("ignored start ndone", 32'(nd), 32'd1);
    check("ignored start lat", 32'(dc), 32'd27);
    check("ignored start dst", dr, 32'h40400000);
    check("dst hold", dst1, 32'h40400000);

    // start held through done is taken the cycle after done
    @(negedge clk);
    srca = 32'h3F800000;
    srcb = 32'h40400000;
    st1  = 1'b1;
    @(posedge clk);
    #1;
    st1 = 1'b0;
    nd  = 0;
    dc  = 0;
    dc2 = 0;
    dr  = 32'h0;
    for (int c = 1; c < 80; c++) begin
      if (c == 29) st1 = 1'b0;
      if (done1) begin
        nd++;
        if (nd == 1) begin
          dc = c;
          check("b2b first dst", dst1, 32'h3EAAAAAA);
          srca = 32'h40C00000;
          srcb = 32'h40000000;
          st1  = 1'b1;
        end else begin
          dc2 = c;
          dr  = dst1;
        end
      end
      @(posedge clk);
      #1;
    end
    st1 = 1'b0;
    check("b2b ndone", 32'(nd), 32'd2);
    check("b2b first lat", 32'(dc), 32'd27);
    check("b2b second at", 32'(dc2), 32'd55);
    check("b2b second dst", dr, 32'h40400000);

    // reset in the middle of an operation
    @(negedge clk);
    srca = 32'h40C00000;
    srcb = 32'h40000000;
    st1  = 1'b1;
    @(posedge clk);
    #1;
    st1 = 1'b0;
    for (int c = 1; c < 12; c++) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    check("midrst busy", 32'(busy1), 32'h0);
    check("midrst done", 32'(done1), 32'h0);
    check("midrst dst", dst1, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (done1) nd++;
    end
    check("midrst no done", 32'(nd), 32'd0);
    check("midrst dst kept", dst1, 32'h0);
    op(32'h40C00000, 32'h40000000, 1'b0, r, lat, bb);
    check("post rst dst", r, 32'h40400000);
    check("post rst lat", 32'(lat), 32'd27);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
